// File: rtl/bp_nonsynth_heartbeat_arbiter.sv
// bp_nonsynth_heartbeat_arbiter: per-core heartbeat/timeout monitors feeding a round-robin event arbiter
module bp_nonsynth_heartbeat_arbiter #(
  parameter int num_core_p = 2,
  parameter int heartbeat_instr_p = 1024,
  parameter int timeout_cycles_p = 4096,
  parameter int instr_cnt_width_p = 32,
  localparam int core_w = num_core_p > 1 ? $clog2(num_core_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_core_p-1:0]        freeze_i,
  input  logic [num_core_p-1:0]        instret_i,
  output logic                         event_v_o,
  input  logic                         event_ready_i,
  output logic [core_w-1:0]            event_core_o,
  output logic                         event_timeout_o,
  output logic [instr_cnt_width_p-1:0] event_instr_cnt_o,
  output logic                         halt_o,
  output logic                         overflow_o
);
  localparam int phase_w = $clog2(heartbeat_instr_p);
  localparam int stall_w = $clog2(timeout_cycles_p);
  localparam logic [phase_w-1:0] phase_max = phase_w'(heartbeat_instr_p - 1);
  localparam logic [stall_w-1:0] stall_max = stall_w'(timeout_cycles_p - 1);
  localparam logic [stall_w-1:0] stall_arm = stall_w'(timeout_cycles_p - 2);
  localparam logic [core_w:0] n_c = (core_w + 1)'(num_core_p);

  typedef enum logic [1:0] {IDLE, SEND, HALT} state_t;
  state_t state;

  logic [instr_cnt_width_p-1:0] instr_cnt [num_core_p];
  logic [phase_w-1:0] phase [num_core_p];
  logic [stall_w-1:0] stall [num_core_p];
  logic [num_core_p-1:0] hb_pending, to_pending, hb_set, to_set, grant_oh, sel, hi_mask;
  logic [core_w-1:0] rr_ptr, hi, lo, gnt;
  logic [core_w:0] nxt;
  logic accept;

  // timeouts outrank heartbeats; within a class search rr_ptr upward, then wrap
  always_comb begin
    accept = state == SEND && event_ready_i;
    hb_set = '0;
    to_set = '0;
    grant_oh = '0;
    hi_mask = '0;
    sel = |to_pending ? to_pending : hb_pending;
    hi = '0;
    lo = '0;
    for (int c = num_core_p - 1; c >= 0; c--) begin
      hb_set[c] = !freeze_i[c] && instret_i[c] && phase[c] == phase_max;
      to_set[c] = !freeze_i[c] && !instret_i[c] && stall[c] == stall_arm;
      grant_oh[c] = accept && event_core_o == core_w'(c);
      hi_mask[c] = core_w'(c) >= rr_ptr;
      if (sel[c]) lo = core_w'(c);
      if (sel[c] && hi_mask[c]) hi = core_w'(c);
    end
    gnt = |(sel & hi_mask) ? hi : lo;
    nxt = {1'b0, event_core_o} + 1'b1;
  end

  // a fresh set beats the acceptance clear, so only un-renewed flags drop
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_core_p; c++) begin
        instr_cnt[c] <= '0;
        phase[c] <= '0;
        stall[c] <= '0;
      end
      hb_pending <= '0;
      to_pending <= '0;
      overflow_o <= 1'b0;
    end else begin
      for (int c = 0; c < num_core_p; c++) begin
        instr_cnt[c] <= freeze_i[c] ? '0 : instret_i[c] && instr_cnt[c] != '1 ? instr_cnt[c] + 1'b1 : instr_cnt[c];
        phase[c] <= freeze_i[c] ? '0 : !instret_i[c] ? phase[c] : phase[c] == phase_max ? '0 : phase[c] + 1'b1;
        stall[c] <= freeze_i[c] || instret_i[c] ? '0 : stall[c] == stall_max ? stall[c] : stall[c] + 1'b1;
      end
      hb_pending <= ~freeze_i & (hb_set | (hb_pending & ~(grant_oh & {num_core_p{~event_timeout_o}})));
      to_pending <= ~freeze_i & (to_set | (to_pending & ~(grant_oh & {num_core_p{event_timeout_o}})));
      overflow_o <= overflow_o | |(hb_set & hb_pending);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      rr_ptr <= '0;
      event_v_o <= 1'b0;
      event_core_o <= '0;
      event_timeout_o <= 1'b0;
      event_instr_cnt_o <= '0;
      halt_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|sel) begin
          event_v_o <= 1'b1;
          event_core_o <= gnt;
          event_timeout_o <= |to_pending;
          event_instr_cnt_o <= instr_cnt[gnt];
          state <= SEND;
        end
        SEND: if (event_ready_i) begin
          event_v_o <= 1'b0;
          rr_ptr <= nxt == n_c ? '0 : nxt[core_w-1:0];
          halt_o <= event_timeout_o;
          state <= event_timeout_o ? HALT : IDLE;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule
